// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table, gain-compensation shift list and FSM states.
// The COMP state exists only when CORDIC_GAIN_COMP_EN is defined.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROT,
    ST_FIN
`ifdef CORDIC_GAIN_COMP_EN
    , ST_COMP
`endif
  } state_t;

  // round(atan(2^-i) * 2^32 / (2*pi)); full circle = 2^32
  localparam logic [31:0] ATAN32 [32] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
  };

  // 1/K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13; bit k of GAIN_NEG marks a subtracted term
  localparam int              GAIN_TERMS = 5;
  localparam int              GAIN_SHIFT [GAIN_TERMS] = '{1, 3, 6, 9, 13};
  localparam logic [GAIN_TERMS-1:0] GAIN_NEG = 5'b11100;

  function automatic logic [31:0] atan_w(input int i, input int w);
    logic [32:0] r;
    if (w >= 32) return ATAN32[i];
    r = {1'b0, ATAN32[i]} + (33'd1 << (31 - w));
    return 32'(r >> (32 - w));
  endfunction

  function automatic int quarter_turn(input int w);
    return 1 << (w - 2);
  endfunction

endpackage

// File: rtl/cordic_addsub.sv
// Signed W-bit adder/subtractor: y = a - b when sub, else a + b.
module cordic_addsub #(
  parameter int W = 18
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                sub,
  output logic signed [W-1:0] y
);

  assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/cordic_iter_core.sv
// Iterative CORDIC (rotation/vectoring) with quadrant pre-rotation and START/BUSY/DONE handshake.
// Optional gain-compensation stage enabled by defining CORDIC_GAIN_COMP_EN.
module cordic_iter_core
  import cordic_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int ITERS = 14,
  parameter  int GW    = 2,
  localparam int XW    = WIDTH + GW
) (
  input  logic                    C,
  input  logic                    CLR_N,
  input  logic                    CE,
  input  logic                    START,
  input  logic                    MODE,
  input  logic signed [WIDTH-1:0] X_IN,
  input  logic signed [WIDTH-1:0] Y_IN,
  input  logic signed [WIDTH-1:0] Z_IN,
  output logic                    BUSY,
  output logic                    DONE,
  output logic signed [XW-1:0]    X_OUT,
  output logic signed [XW-1:0]    Y_OUT,
  output logic signed [WIDTH-1:0] Z_OUT
);

  localparam int              CW  = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [WIDTH-1:0] QTR = WIDTH'(quarter_turn(WIDTH));

  state_t                  state, state_nxt;
  logic [CW-1:0]           iter;
  logic signed [XW-1:0]    x_r, y_r, x_ld, y_ld, x_ext, y_ext, x_step, y_step;
  logic signed [WIDTH-1:0] z_r, z_ld, z_step;
  logic                    mode_r, load, last, d_pos;
  logic [WIDTH-1:0]        atan_rom [ITERS];

  for (genvar g = 0; g < ITERS; g++) begin : g_atan
    assign atan_rom[g] = WIDTH'(atan_w(g, WIDTH));
  end

  assign x_ext = {{GW{X_IN[WIDTH-1]}}, X_IN};
  assign y_ext = {{GW{Y_IN[WIDTH-1]}}, Y_IN};

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    x_ld = x_ext;
    y_ld = y_ext;
    z_ld = Z_IN;
    if (!MODE) begin
      case (Z_IN[WIDTH-1 -: 2])
        2'b01:   begin x_ld = -y_ext; y_ld = x_ext;  z_ld = Z_IN - QTR; end
        2'b10:   begin x_ld = y_ext;  y_ld = -x_ext; z_ld = Z_IN + QTR; end
        default: ;
      endcase
    end else if (X_IN[WIDTH-1]) begin
      if (!Y_IN[WIDTH-1]) begin x_ld = y_ext;  y_ld = -x_ext; z_ld = Z_IN + QTR; end
      else                begin x_ld = -y_ext; y_ld = x_ext;  z_ld = Z_IN - QTR; end
    end
  end

  // d = +1: rotation drives Z towards 0, vectoring drives Y towards 0
  assign d_pos = mode_r ? y_r[XW-1] : ~z_r[WIDTH-1];
  assign last  = (iter == CW'(ITERS - 1));

  cordic_addsub #(.W(XW))    u_x (.a(x_r), .b(y_r >>> iter), .sub(d_pos),  .y(x_step));
  cordic_addsub #(.W(XW))    u_y (.a(y_r), .b(x_r >>> iter), .sub(~d_pos), .y(y_step));
  cordic_addsub #(.W(WIDTH)) u_z (.a(z_r), .b(atan_rom[iter]), .sub(d_pos), .y(z_step));

`ifdef CORDIC_GAIN_COMP_EN
  function automatic logic signed [XW-1:0] gain_comp(input logic signed [XW-1:0] v);
    logic signed [XW-1:0] acc;
    acc = '0;
    for (int k = 0; k < GAIN_TERMS; k++) begin
      if (GAIN_NEG[k]) acc = acc - (v >>> GAIN_SHIFT[k]);
      else             acc = acc + (v >>> GAIN_SHIFT[k]);
    end
    return acc;
  endfunction
`endif

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: if (START) begin state_nxt = ST_ROT; load = 1'b1; end
`ifdef CORDIC_GAIN_COMP_EN
      ST_ROT:  if (last) state_nxt = ST_COMP;
      ST_COMP: state_nxt = ST_FIN;
`else
      ST_ROT:  if (last) state_nxt = ST_FIN;
`endif
      ST_FIN: begin
        state_nxt = ST_IDLE;
        if (START) begin state_nxt = ST_ROT; load = 1'b1; end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N)  state <= ST_IDLE;
    else if (CE) state <= state_nxt;
  end

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
      mode_r <= 1'b0;
      iter   <= '0;
      X_OUT  <= '0;
      Y_OUT  <= '0;
      Z_OUT  <= '0;
    end else if (CE) begin
      if (load) begin
        x_r    <= x_ld;
        y_r    <= y_ld;
        z_r    <= z_ld;
        mode_r <= MODE;
        iter   <= '0;
      end else if (state == ST_ROT) begin
        x_r <= x_step;
        y_r <= y_step;
        z_r <= z_step;
        if (!last) iter <= iter + 1'b1;
`ifndef CORDIC_GAIN_COMP_EN
        if (last) begin
          X_OUT <= x_step;
          Y_OUT <= y_step;
          Z_OUT <= z_step;
        end
`endif
      end
`ifdef CORDIC_GAIN_COMP_EN
      else if (state == ST_COMP) begin
        X_OUT <= gain_comp(x_r);
        Y_OUT <= gain_comp(y_r);
        Z_OUT <= z_r;
      end
`endif
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  assign BUSY = (state == ST_ROT) || (state == ST_COMP);
`else
  assign BUSY = (state == ST_ROT);
`endif
  assign DONE = (state == ST_FIN);

endmodule

// File: tb/tb_cordic_iter_core.sv
// Self-checking bench for cordic_iter_core: floating-point reference model feeding a scoreboard queue.
module tb_cordic_iter_core;

  localparam int  WIDTH = 16;
  localparam int  ITERS = 14;
  localparam int  GW    = 2;
  localparam int  XW    = WIDTH + GW;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int  LAT   = ITERS + 2;
  localparam real COMP  = 0.5 + 0.125 - 1.0/64.0 - 1.0/512.0 - 1.0/8192.0;
`else
  localparam int  LAT   = ITERS + 1;
  localparam real COMP  = 1.0;
`endif
  localparam int  TOL_XY = 16;
  localparam int  TOL_ZR = 4;
  localparam int  TOL_ZV = 12;
  localparam real PI     = 3.14159265358979;

  logic C = 1'b0, CLR_N = 1'b1, CE = 1'b1, START = 1'b0, MODE = 1'b0;
  logic signed [WIDTH-1:0] X_IN = '0, Y_IN = '0, Z_IN = '0;
  logic BUSY, DONE;
  logic signed [XW-1:0]    X_OUT, Y_OUT;
  logic signed [WIDTH-1:0] Z_OUT;

  always #5 C = ~C;

  cordic_iter_core #(.WIDTH(WIDTH), .ITERS(ITERS), .GW(GW)) dut (
    .C(C), .CLR_N(CLR_N), .CE(CE), .START(START), .MODE(MODE),
    .X_IN(X_IN), .Y_IN(Y_IN), .Z_IN(Z_IN),
    .BUSY(BUSY), .DONE(DONE), .X_OUT(X_OUT), .Y_OUT(Y_OUT), .Z_OUT(Z_OUT)
  );

  typedef struct {
    string name;
    bit    mode;
    int    ex, ey, ez;
    int    start_edge;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;
  int   en_edge = 0, last_done_edge = -1;
  real  gain;

  task automatic check(input string tag, input int got, input int want, input int tol = 0);
    int diff;
    diff = got - want;
    checks++;
    if (diff > tol || diff < -tol) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, want, tol);
    end
  endtask

  function automatic int rnd(input real r);
    return $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
  endfunction

  function automatic int wrap16(input int v);
    int m;
    m = v % 65536;
    if (m < 0) m += 65536;
    if (m >= 32768) m -= 65536;
    return m;
  endfunction

  function automatic exp_t model(input string name, input bit mode, input int x, input int y,
                                 input int z, input int se);
    exp_t m;
    real  th, xr, yr;
    xr = real'(x);
    yr = real'(y);
    th = real'(z) * 2.0 * PI / 65536.0;
    m.name = name;
    m.mode = mode;
    m.start_edge = se;
    if (!mode) begin
      m.ex = rnd(gain * (xr * $cos(th) - yr * $sin(th)));
      m.ey = rnd(gain * (xr * $sin(th) + yr * $cos(th)));
      m.ez = 0;
    end else begin
      m.ex = rnd(gain * $sqrt(xr * xr + yr * yr));
      m.ey = 0;
      m.ez = wrap16(rnd(real'(z) + $atan2(yr, xr) * 65536.0 / (2.0 * PI)));
    end
    return m;
  endfunction

  always @(posedge C) if (CE) en_edge++;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge C);
      if (CLR_N && DONE && en_edge != last_done_edge) begin
        last_done_edge = en_edge;
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check({e.name, "_latency"}, en_edge - e.start_edge + 1, LAT);
          check({e.name, "_x"}, int'(X_OUT), e.ex, TOL_XY);
          check({e.name, "_y"}, int'(Y_OUT), e.ey, TOL_XY);
          check({e.name, "_z_err"}, wrap16(int'(Z_OUT) - e.ez), 0, e.mode ? TOL_ZV : TOL_ZR);
        end
      end
    end
  end

  task automatic issue(input string name, input bit mode, input int x, input int y, input int z,
                       input bit track = 1'b1);
    @(negedge C);
    MODE  = mode;
    X_IN  = WIDTH'(x);
    Y_IN  = WIDTH'(y);
    Z_IN  = WIDTH'(z);
    START = 1'b1;
    if (track) sb.push_back(model(name, mode, x, y, z, en_edge + 1));
    @(negedge C);
    START = 1'b0;
    check({name, "_busy"}, int'(BUSY), 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge C);
      if (sb.size() == 0) return;
    end
    check({tag, "_timeout"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin : stimulus
    int x, y, z, s;
    bit seen;
    gain = COMP;
    for (int i = 0; i < ITERS; i++) gain *= $sqrt(1.0 + 2.0 ** (-2.0 * real'(i)));

    #1 CLR_N = 1'b0;
    repeat (2) @(negedge C);
    check("rst_busy", int'(BUSY), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_x", int'(X_OUT), 0);
    check("rst_y", int'(Y_OUT), 0);
    check("rst_z", int'(Z_OUT), 0);
    CLR_N = 1'b1;
    @(negedge C);

    issue("rot45", 1'b0, 10000, 0, 'h2000);        wait_idle("rot45", 3 * LAT);
    issue("vec127", 1'b1, -3000, 4000, 0);         wait_idle("vec127", 3 * LAT);
    issue("rot_m180", 1'b0, 1000, 0, -32768);      wait_idle("rot_m180", 3 * LAT);
    issue("rot_q01", 1'b0, 8000, 2000, 'h6000);    wait_idle("rot_q01", 3 * LAT);
    issue("rot_q10", 1'b0, -7000, 5000, -24576);   wait_idle("rot_q10", 3 * LAT);
    issue("vec_q3", 1'b1, -5000, -2000, 'h1000);   wait_idle("vec_q3", 3 * LAT);
    issue("rot_zero", 1'b0, 10000, 0, 0);          wait_idle("rot_zero", 3 * LAT);

    for (int k = 0; k < 4; k++) begin
      x = int'($urandom_range(24000)) - 12000;
      y = int'($urandom_range(24000)) - 12000;
      z = int'($urandom_range(65535)) - 32768;
      issue("rot_rand", 1'b0, x, y, z);
      wait_idle("rot_rand", 3 * LAT);
    end
    for (int k = 0; k < 4; k++) begin
      x = int'($urandom_range(6000)) + 6000;
      if ($urandom_range(1) == 1) x = -x;
      y = int'($urandom_range(24000)) - 12000;
      z = int'($urandom_range(65535)) - 32768;
      issue("vec_rand", 1'b1, x, y, z);
      wait_idle("vec_rand", 3 * LAT);
    end

    // START held high: three operations back to back, one every LAT enabled edges
    @(negedge C);
    MODE = 1'b0; X_IN = 16'sd8000; Y_IN = -16'sd3000; Z_IN = 16'sh1000; START = 1'b1;
    s = en_edge + 1;
    for (int k = 0; k < 3; k++) sb.push_back(model("b2b", 1'b0, 8000, -3000, 'h1000, s + k * LAT));
    repeat (2 * LAT + 1) @(negedge C);
    START = 1'b0;
    wait_idle("b2b", 3 * LAT);

    // START pulsed mid-operation with different operands must be ignored
    issue("ign", 1'b0, 6000, 2000, 'h3000);
    repeat (4) @(negedge C);
    MODE = 1'b1; X_IN = -16'sd9000; Y_IN = 16'sd1234; Z_IN = 16'sh7000; START = 1'b1;
    @(negedge C);
    START = 1'b0;
    wait_idle("ign", 3 * LAT);
    repeat (LAT + 3) @(negedge C);

    // CE low for 5 cycles mid-operation: enabled-edge latency and results unchanged
    issue("ce_stall", 1'b0, 9000, -4000, 'h0C00);
    repeat (3) @(negedge C);
    CE = 1'b0;
    repeat (5) @(negedge C);
    CE = 1'b1;
    wait_idle("ce_stall", 3 * LAT);

    // DONE is held while CE is low and drops once CE returns
    issue("done_hold", 1'b1, 7000, 3000, 0);
    seen = 1'b0;
    for (int n = 0; n < 3 * LAT && !seen; n++) begin
      @(negedge C);
      seen = DONE;
    end
    check("done_hold_seen", int'(seen), 1);
    CE = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge C);
      check("done_hold_level", int'(DONE), 1);
    end
    CE = 1'b1;
    @(negedge C);
    check("done_hold_drop", int'(DONE), 0);
    wait_idle("done_hold", 3 * LAT);

    // Asynchronous reset mid-operation: immediate clear, no DONE afterwards
    issue("rst_mid", 1'b0, 5000, 5000, 'h1800, 1'b0);
    repeat (4) @(negedge C);
    #2 CLR_N = 1'b0;
    #1;
    check("rst_mid_busy", int'(BUSY), 0);
    check("rst_mid_done", int'(DONE), 0);
    check("rst_mid_x", int'(X_OUT), 0);
    check("rst_mid_y", int'(Y_OUT), 0);
    check("rst_mid_z", int'(Z_OUT), 0);
    @(negedge C);
    CLR_N = 1'b1;
    repeat (LAT + 5) @(negedge C);

    issue("after_rst", 1'b0, -6000, 8000, -'h1400);
    wait_idle("after_rst", 3 * LAT);
    repeat (3) @(negedge C);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
